// File: rtl/gol_scheduler_pkg.sv
// Shared encodings for the Game of Life generation scheduler.
// No logic; scheduler states, LOAD-exit routing and grid geometry.
// Imported by the scheduler top and its bench.
package gol_scheduler_pkg;

  localparam int GRID_SIZE = 64;

  typedef enum logic [1:0] {
    PAUSED,
    LOAD,
    WAIT,
    STEP
  } gol_sched_state_t;

  // Records why LOAD was entered so its exit knows whether a step follows.
  typedef enum logic {
    LOAD_RUN,
    LOAD_STEP
  } gol_req_t;

endpackage

// File: rtl/gol_scheduler_if.sv
// Scheduler <-> engine request/acknowledge handshake.
// Requests are levels held until a one-cycle ack; ack outside a request is ignored.
// The engine cannot stall the scheduler other than by withholding ack.
interface gol_scheduler_if;
  logic engine_step;
  logic engine_load;
  logic engine_ack;

  modport master (output engine_step, output engine_load, input engine_ack);
  modport slave  (input engine_step, input engine_load, output engine_ack);
endinterface

// File: rtl/gol_tick_divider.sv
// Generation pacing counter; period = TICK_BASE >> speed cycles.
// Combinational one-cycle tick when the count reaches period-1; counter restarts at 0.
// clear holds the count at 0 and suppresses the tick; no other stall.
module gol_tick_divider #(
  parameter int TICK_BASE = 1_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       enable,
  input  logic [1:0] speed,
  output logic       tick
);

  localparam int CNT_W = $clog2(TICK_BASE);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      period_m1;
  logic             at_end;

  always_comb begin
    period_m1 = (32'(TICK_BASE) >> speed) - 32'd1;
    at_end    = (32'(cnt_q) == period_m1);
    tick      = enable && !clear && at_end;
    cnt_d     = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = at_end ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/gol_scheduler.sv
// Run/pause sequencer issuing step/load requests to the GoL engine (GOL_SINGLE_STEP_EN adds step button).
// Requests rise the cycle the FSM enters LOAD/STEP and fall the cycle after ack; outputs registered.
// Engine backpressure is ack withholding only; requests are never aborted except by reset.
module gol_scheduler
  import gol_scheduler_pkg::*;
#(
  parameter int TICK_BASE = 1_000_000,
  parameter int GEN_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pause,
  input  logic             step_btn,
  input  logic [1:0]       speed,
  input  logic             edit_dirty,
  gol_scheduler_if.master  eng,
  output logic             grid_sel,
  output logic [GEN_W-1:0] generation,
  output logic             busy
);

  gol_sched_state_t state_q, state_d;
  gol_req_t         load_kind_q, load_kind_d;
  logic             dirty_q, dirty_d;
  logic [1:0]       speed_q, speed_d;
  logic [GEN_W-1:0] gen_q, gen_d;
  logic             step_q, step_d;
  logic             load_q, load_d;
  logic             grid_sel_q, grid_sel_d;
  logic             busy_q, busy_d;
  logic             step_edge;
  logic             tick;
  logic             div_clear;

`ifdef GOL_SINGLE_STEP_EN
  logic step_btn_q, step_btn_d;

  assign step_btn_d = step_btn;
  assign step_edge  = step_btn && !step_btn_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      step_btn_q <= 1'b0;
    end else begin
      step_btn_q <= step_btn_d;
    end
  end
`else
  logic unused_step_btn;

  assign unused_step_btn = step_btn;
  assign step_edge       = 1'b0;
`endif

  // The count only runs in WAIT; pausing clears it so a resume starts a full period.
  assign div_clear = (state_q != WAIT) || pause;

  gol_tick_divider #(
    .TICK_BASE (TICK_BASE)
  ) u_tick_divider (
    .clk    (clk),
    .reset  (reset),
    .clear  (div_clear),
    .enable (1'b1),
    .speed  (speed_q),
    .tick   (tick)
  );

  always_comb begin
    state_d     = state_q;
    load_kind_d = load_kind_q;
    dirty_d     = dirty_q;
    speed_d     = speed_q;
    gen_d       = gen_q;

    case (state_q)
      PAUSED: begin
        if (!pause) begin
          state_d     = dirty_q ? LOAD : WAIT;
          load_kind_d = LOAD_RUN;
        end else if (step_edge) begin
          state_d     = dirty_q ? LOAD : STEP;
          load_kind_d = LOAD_STEP;
        end
      end
      LOAD: begin
        if (eng.engine_ack) begin
          gen_d   = '0;
          dirty_d = 1'b0;
          if (!pause) begin
            state_d = WAIT;
          end else if (load_kind_q == LOAD_STEP) begin
            state_d = STEP;
          end else begin
            state_d = PAUSED;
          end
        end
      end
      WAIT: begin
        if (pause) begin
          state_d = PAUSED;
        end else if (tick) begin
          state_d = STEP;
        end
      end
      STEP: begin
        if (eng.engine_ack) begin
          gen_d   = gen_q + GEN_W'(1);
          state_d = pause ? PAUSED : WAIT;
        end
      end
      default: state_d = PAUSED;
    endcase

    // A new edit overrides the clear from a coincident load ack.
    if (edit_dirty) begin
      dirty_d = 1'b1;
    end

    if ((state_d == WAIT) && (state_q != WAIT)) begin
      speed_d = speed;
    end

    step_d = (state_d == STEP);
    load_d = (state_d == LOAD);
    busy_d = step_d || load_d;

    grid_sel_d = grid_sel_q;
    if (state_d == PAUSED) begin
      grid_sel_d = 1'b1;
    end else if (state_d == WAIT) begin
      grid_sel_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= PAUSED;
      load_kind_q <= LOAD_RUN;
      dirty_q     <= 1'b0;
      speed_q     <= 2'd0;
      gen_q       <= '0;
      step_q      <= 1'b0;
      load_q      <= 1'b0;
      grid_sel_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      load_kind_q <= load_kind_d;
      dirty_q     <= dirty_d;
      speed_q     <= speed_d;
      gen_q       <= gen_d;
      step_q      <= step_d;
      load_q      <= load_d;
      grid_sel_q  <= grid_sel_d;
      busy_q      <= busy_d;
    end
  end

  assign eng.engine_step = step_q;
  assign eng.engine_load = load_q;
  assign grid_sel        = grid_sel_q;
  assign generation      = gen_q;
  assign busy            = busy_q;

endmodule

// File: tb/tb_gol_scheduler.sv
// Directed bench for gol_scheduler: expected engine requests are queued by the stimulus
// and a negedge monitor pops and compares each request as it appears.
module tb_gol_scheduler;

  typedef struct {
    bit is_load;
    int gen;
    int gap;
    int at;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       pause;
  logic       step_btn;
  logic [1:0] speed;
  logic       edit_dirty;
  logic       grid_sel;
  logic [15:0] generation;
  logic       busy;

  logic       rst2;
  logic       pause2;
  logic       grid_sel2;
  logic [3:0] generation2;
  logic       busy2;

  logic resp_ack  = 1'b0;
  logic stray_ack = 1'b0;
  bit   ack_en    = 1'b1;
  int   ack_dly   = 2;
  int   ack_cnt   = 0;
  logic rsp_ps = 1'b0, rsp_pl = 1'b0, rs, rl;
  logic mon_ps = 1'b0, mon_pl = 1'b0, ms, ml;
  int   mon_last = 0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  bit   wrap_done = 1'b0;
  exp_t exp_q[$];

  gol_scheduler_if eng ();
  gol_scheduler_if eng2 ();

  gol_scheduler #(.TICK_BASE(16), .GEN_W(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .pause      (pause),
    .step_btn   (step_btn),
    .speed      (speed),
    .edit_dirty (edit_dirty),
    .eng        (eng),
    .grid_sel   (grid_sel),
    .generation (generation),
    .busy       (busy)
  );

  // Narrow counter instance so the wrap is reachable in a few dozen cycles.
  gol_scheduler #(.TICK_BASE(16), .GEN_W(4)) dut_wrap (
    .clk        (clk),
    .reset      (rst2),
    .pause      (pause2),
    .step_btn   (1'b0),
    .speed      (2'd3),
    .edit_dirty (1'b0),
    .eng        (eng2),
    .grid_sel   (grid_sel2),
    .generation (generation2),
    .busy       (busy2)
  );

  assign eng.engine_ack  = resp_ack | stray_ack;
  assign eng2.engine_ack = eng2.engine_step | eng2.engine_load;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic expect_req(input bit is_load, input int gen, input int gap, input int at);
    exp_t e;
    e.is_load = is_load; e.gen = gen; e.gap = gap; e.at = at;
    exp_q.push_back(e);
  endtask

  task automatic wait_q(input int n);
    int b = 0;
    while (exp_q.size() > n && b < 200) begin
      tick(1);
      b++;
    end
    if (exp_q.size() > n) begin
      check("timeout_waiting_request", exp_q.size(), n);
      exp_q.delete();
    end
  endtask

  task automatic wait_req_low(output int held);
    int b = 0;
    held = 0;
    while ((eng.engine_step || eng.engine_load) && b < 60) begin
      held++;
      b++;
      tick(1);
    end
    if (b >= 60) check("timeout_request_stuck", 1, 0);
  endtask

  // Engine model: acks ack_dly cycles after each new request.
  always @(negedge clk) begin
    rs = eng.engine_step;
    rl = eng.engine_load;
    if ((rs && !rsp_ps) || (rl && !rsp_pl)) ack_cnt = 0;
    resp_ack = 1'b0;
    if ((rs || rl) && ack_en) begin
      if (ack_cnt == ack_dly) resp_ack = 1'b1;
      ack_cnt++;
    end
    rsp_ps = rs;
    rsp_pl = rl;
  end

  always @(negedge clk) begin
    exp_t e;
    ms = eng.engine_step;
    ml = eng.engine_load;
    if (!reset && ((ms && !mon_ps) || (ml && !mon_pl))) begin
      check("req_exclusive", longint'(ms && ml), 0);
      if (exp_q.size() == 0) begin
        check("unexpected_request", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("req_kind_is_load", longint'(ml), longint'(e.is_load));
        check("req_generation", generation, e.gen);
        if (e.gap >= 0) check("req_gap_cycles", cyc - mon_last, e.gap);
        if (e.at >= 0) check("req_start_cycle", cyc, e.at);
      end
      mon_last = cyc;
    end
    mon_ps = ms;
    mon_pl = ml;
  end

  initial begin : wrap_proc
    int cnt = 0;
    int b = 0;
    rst2 = 1'b1;
    pause2 = 1'b1;
    tick(2);
    rst2 = 1'b0;
    pause2 = 1'b0;
    while (cnt < 18 && b < 300) begin
      tick(1);
      b++;
      if (eng2.engine_step) begin
        if (cnt >= 15) check("wrap_generation", generation2, cnt % 16);
        cnt++;
      end
    end
    if (cnt < 18) check("timeout_wrap", cnt, 18);
    pause2 = 1'b1;
    wrap_done = 1'b1;
  end

  initial begin : main_proc
    int held;
    int b;
    reset = 1'b1; pause = 1'b1; step_btn = 1'b0; speed = 2'd0; edit_dirty = 1'b0;
    tick(2);
    check("reset_grid_sel", grid_sel, 1);
    check("reset_generation", generation, 0);
    check("reset_engine_step", eng.engine_step, 0);
    check("reset_engine_load", eng.engine_load, 0);
    check("reset_busy", busy, 0);
    reset = 1'b0;
    tick(3);

    stray_ack = 1'b1; tick(1); stray_ack = 1'b0; tick(2);
    check("stray_ack_gen", generation, 0);
    check("stray_ack_busy", busy, 0);

    // Free run, speed 0, 2-cycle engine latency.
    expect_req(0, 0, -1, cyc + 17);
    expect_req(0, 1, 19, -1);
    expect_req(0, 2, 19, -1);
    pause = 1'b0;
    wait_q(2);
    check("busy_in_step", busy, 1);
    wait_req_low(held);
    check("step_pulse_len", held, 3);
    check("run_grid_sel", grid_sel, 0);
    check("run_busy_wait", busy, 0);
    check("run_gen_after_first", generation, 1);
    wait_q(0);
    pause = 1'b1;
    wait_req_low(held);
    tick(1);
    check("run_gen_three", generation, 3);
    check("run_paused_grid_sel", grid_sel, 1);

    // Speed 2; a mid-count speed change only applies from the next WAIT.
    speed = 2'd2;
    expect_req(0, 3, -1, cyc + 5);
    expect_req(0, 4, 7, -1);
    expect_req(0, 5, 7, -1);
    expect_req(0, 6, 7, -1);
    expect_req(0, 7, 19, -1);
    pause = 1'b0;
    wait_q(2);
    wait_req_low(held);
    tick(1);
    speed = 2'd0;
    wait_q(1);
    wait_req_low(held);
    ack_dly = 5;
    wait_q(0);
    pause = 1'b1;
    wait_req_low(held);
    check("pause_mid_step_held", held, 6);
    tick(1);
    check("pause_mid_step_gen", generation, 8);
    check("pause_mid_step_grid_sel", grid_sel, 1);
    check("pause_mid_step_busy", busy, 0);
    ack_dly = 2;

    // Pause from WAIT, then resume with a full period.
    pause = 1'b0; tick(6); pause = 1'b1; tick(1);
    check("pause_from_wait_grid_sel", grid_sel, 1);
    check("pause_from_wait_busy", busy, 0);
    tick(3);
    expect_req(0, 8, -1, cyc + 17);
    pause = 1'b0;
    wait_q(0);
    pause = 1'b1;
    wait_req_low(held);
    tick(1);
    check("resume_gen", generation, 9);

    // Edit then run: load first, generation cleared, dirty consumed.
    edit_dirty = 1'b1; tick(1); edit_dirty = 1'b0; tick(2);
    expect_req(1, 9, -1, cyc + 1);
    expect_req(0, 0, 19, -1);
    pause = 1'b0;
    wait_q(1);
    wait_req_low(held);
    check("load_clears_gen", generation, 0);
    check("load_then_wait_grid_sel", grid_sel, 0);
    wait_q(0);
    pause = 1'b1;
    wait_req_low(held);
    tick(1);
    check("edit_run_gen", generation, 1);
    expect_req(0, 1, -1, cyc + 17);
    pause = 1'b0;
    wait_q(0);
    pause = 1'b1;
    wait_req_low(held);
    tick(1);
    check("dirty_cleared_gen", generation, 2);

    // Edit coinciding with the load ack keeps the grid dirty.
    edit_dirty = 1'b1; tick(1); edit_dirty = 1'b0; tick(1);
    ack_en = 1'b0;
    expect_req(1, 2, -1, cyc + 1);
    pause = 1'b0;
    wait_q(0);
    pause = 1'b1;
    tick(2);
    check("load_held_without_ack", eng.engine_load, 1);
    stray_ack = 1'b1; edit_dirty = 1'b1; tick(1);
    stray_ack = 1'b0; edit_dirty = 1'b0; tick(1);
    check("load_dropped_after_ack", eng.engine_load, 0);
    check("load_pause_gen", generation, 0);
    check("load_pause_grid_sel", grid_sel, 1);
    ack_en = 1'b1;
    expect_req(1, 0, -1, cyc + 1);
    expect_req(0, 0, 19, -1);
    pause = 1'b0;
    wait_q(1);
    wait_req_low(held);
    wait_q(0);
    pause = 1'b1;
    wait_req_low(held);
    tick(1);
    check("dirty_set_wins_gen", generation, 1);

    // Step button edges while running are discarded.
    pause = 1'b0; tick(4);
    step_btn = 1'b1; tick(2); step_btn = 1'b0; tick(2);
    pause = 1'b1; tick(5);
    check("step_in_wait_discarded_busy", busy, 0);
    check("step_in_wait_discarded_gen", generation, 1);

`ifdef GOL_SINGLE_STEP_EN
    expect_req(0, 1, -1, cyc + 1);
    step_btn = 1'b1; tick(10); step_btn = 1'b0; tick(3);
    check("single_step_gen", generation, 2);
    check("single_step_grid_sel", grid_sel, 1);
    check("single_step_busy", busy, 0);
    edit_dirty = 1'b1; tick(1); edit_dirty = 1'b0; tick(1);
    expect_req(1, 2, -1, cyc + 1);
    expect_req(0, 0, 3, -1);
    step_btn = 1'b1; tick(10); step_btn = 1'b0; tick(3);
    check("single_step_load_gen", generation, 1);
    check("single_step_load_grid_sel", grid_sel, 1);
    check("single_step_load_busy", busy, 0);
`else
    step_btn = 1'b1; tick(10); step_btn = 1'b0; tick(3);
    check("step_btn_ignored_gen", generation, 1);
    check("step_btn_ignored_busy", busy, 0);
`endif

    // Reset while a request is outstanding drops it next cycle.
    ack_en = 1'b0;
    expect_req(0, 1, -1, cyc + 17);
    pause = 1'b0;
    wait_q(0);
    tick(1);
    reset = 1'b1;
    tick(1);
    check("reset_drops_step", eng.engine_step, 0);
    check("reset_mid_gen", generation, 0);
    check("reset_mid_grid_sel", grid_sel, 1);
    reset = 1'b0;
    pause = 1'b1;
    ack_en = 1'b1;
    tick(3);

    b = 0;
    while (!wrap_done && b < 500) begin
      tick(1);
      b++;
    end
    check("wrap_finished", longint'(wrap_done), 1);
    check("exp_queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gol_scheduler.md
# gol_scheduler

Generation sequencer for the Game of Life engine. It owns the run/pause state of the simulation, paces generations with a programmable tick divider, and issues step and load requests to the engine over a request/acknowledge handshake. It also selects whether the display shows the editor grid or the engine grid. It sits between the input controller (pause switch, edit activity) and the engine that computes the next grid.

## Interface
- TICK_BASE, 1_000_000: clock cycles per generation at speed 0; must be ≥ 8.
- GEN_W, 16: width of the generation counter.

- clk  in  1  system clock
- reset  in  1  synchronous, active-high; clears all state
- pause  in  1  level; 1 = paused (editing allowed), 0 = running
- step_btn  in  1  raw single-step button level; rising edge detected internally
- speed  in  2  period select; period = TICK_BASE >> speed cycles
- edit_dirty  in  1  pulse or level from the editor; editor grid was modified
- engine_ack  in  1  one-cycle acknowledge from the engine for the current request
- engine_step  out  1  request: compute one generation; held until ack
- engine_load  out  1  request: copy editor grid into engine; held until ack
- grid_sel  out  1  display source; 1 = editor grid, 0 = engine grid
- generation  out  GEN_W  generations completed since last load or reset
- busy  out  1  high in LOAD or STEP (handshake outstanding)

## Operation
- States: PAUSED, LOAD, WAIT, STEP.
- Reset values:
  - state = PAUSED
  - all outputs 0, except grid_sel = 1
  - dirty latch 0, tick counter 0, step edge register 0
- Dirty latch:
  - Set in any cycle where edit_dirty = 1.
  - Cleared in the cycle LOAD sees engine_ack.
  - If edit_dirty = 1 and ack occur in the same cycle, set wins.
- PAUSED (grid_sel = 1):
  - If pause = 0: go to LOAD if dirty, else WAIT.
  - Else, on a step_btn rising edge: go to LOAD if dirty, else STEP.
- LOAD:
  - engine_load = 1 until ack.
  - On ack, generation is cleared to 0, then:
    - pause = 0 → WAIT.
    - pause = 1 and the load came from a step → STEP.
    - otherwise → PAUSED.
- WAIT (grid_sel = 0):
  - Counter increments from 0.
  - Counter == period−1 → STEP.
  - pause = 1 → PAUSED and counter cleared. This takes priority over the tick.
- STEP:
  - engine_step = 1 until ack.
  - On ack, generation increments, wrapping from 2^GEN_W−1 to 0.
  - Then: pause = 1 → PAUSED, else WAIT with counter 0.
- Requests are never aborted. A pause asserted during LOAD or STEP takes effect after the ack.
- engine_step and engine_load are never high together.
- engine_ack is ignored when no request is outstanding.
- speed is sampled on each WAIT entry. Changes mid-count apply from the next generation.
- step_btn edges outside PAUSED are discarded, not queued.

## Timing
- All outputs are registered.
- Requests assert the cycle after the state transition that enters LOAD or STEP.
- Each request deasserts the cycle after ack is sampled high. Zero-wait ack gives a 1-cycle request pulse.
- Running generation cadence = period cycles in WAIT + 1 entry cycle + engine latency.
- pause → PAUSED from WAIT takes 1 cycle. grid_sel goes to 1 in the same cycle as the state change.
- Reset mid-handshake drops the request in the next cycle. The engine must tolerate an abandoned request.

## Configuration
- GOL_SINGLE_STEP_EN defined:
  - step_btn edge detection and the PAUSED → STEP/LOAD single-step path are present.
- GOL_SINGLE_STEP_EN undefined:
  - The step_btn port remains but is ignored.
  - PAUSED leaves only on pause = 0.
  - LOAD with pause = 1 always returns to PAUSED.

## Structure
- In types.sv:
  - state enum gol_sched_state_t.
  - request type (LOAD_RUN, LOAD_STEP) used to route LOAD exit.
  - GRID_SIZE stays there unchanged.
- Sub-module gol_tick_divider:
  - Counter of width $clog2(TICK_BASE).
  - Inputs: clear, enable, speed.
  - Output: one-cycle tick at period−1.

## Test plan
Bench uses TICK_BASE = 16.
- **Reset:** reset 1 cycle → state PAUSED, grid_sel = 1, generation = 0, engine_step = engine_load = 0.
- **Free run:** pause = 0, speed = 0, ack 2 cycles after each request → engine_step every 16+1+2 cycles; generation = 3 after three acks. With speed = 2 the period is 4 cycles.
- **Edit then run:** pause = 1, edit_dirty pulse, pause = 0 → engine_load first; ack → generation = 0 and dirty cleared; then WAIT.
- **Pause mid-STEP:** pause = 1 while engine_step is high, ack 5 cycles later → request held until ack; generation +1; PAUSED; grid_sel = 1.
- **Single step (macro on):** paused, step_btn held high 10 cycles → exactly one engine_step, generation +1, back to PAUSED. With dirty set: LOAD, then STEP, then PAUSED, generation = 1.
- **Wrap:** preload generation = 0xFFFF, one STEP acked → generation = 0x0000.
